puf_sweep_engine: RTL and testbench
===================================

Name: puf_sweep_engine

Overview:
Parametrised successor to the single-shot delay PUF: a sequencer that drives NUM_CHANNELS parallel delay-PUF cores through a range of challenges and majority-votes VOTES evaluations per challenge. It synchronises each raw core result internally and flags unstable bits. Each per-challenge response is emitted on a valid/ready stream. It sits between the PUF cores and the signature/key-extraction logic, replacing the manual run/challenge toggling used for single-core tests.

Parameters:
CHALLENGE_WIDTH, 8, width of challenge bus and challenge counter
NUM_CHANNELS, 1, number of parallel PUF cores sharing one challenge
PHASE_CYCLES, 10, clk cycles spent in each of PRECHARGE and EVAL (min 1)
SYNC_STAGES, 2, flip-flop stages on each puf_result bit (min 2)
VOTES, 3, evaluations per challenge; odd, 1..15

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; accepted only in IDLE
challenge_base  in  CHALLENGE_WIDTH  first challenge, latched on start
challenge_count  in  CHALLENGE_WIDTH+1  number of challenges, latched on start; 0 = full 2^CHALLENGE_WIDTH
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse after the last response is accepted
puf_challenge  out  CHALLENGE_WIDTH  challenge to all cores
puf_run  out  NUM_CHANNELS  launch strobe per core, all driven identically
puf_result  in  NUM_CHANNELS  raw asynchronous core outputs
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts when high with resp_valid
resp_challenge  out  CHALLENGE_WIDTH  challenge of this response
resp_data  out  NUM_CHANNELS  majority-voted bit per channel
resp_unstable  out  NUM_CHANNELS  1 = votes were not unanimous

Behaviour:
- Reset (reset low, async): state IDLE; busy=0, done=0, puf_run=0, puf_challenge=0, resp_valid=0, resp_challenge=0, resp_data=0, resp_unstable=0, vote counters and synchroniser flops cleared.
- FSM: IDLE -> PRECHARGE -> EVAL -> SAMPLE -> (PRECHARGE | OUTPUT) -> (PRECHARGE | DONE) -> IDLE.
- IDLE: start=1 latches base/count, loads current challenge = base, busy=1 next cycle, goes to PRECHARGE. start while busy is ignored.
- PRECHARGE: puf_run=0 for PHASE_CYCLES cycles; puf_challenge holds the current challenge and changes only on entry to PRECHARGE for a new challenge.
- EVAL: puf_run=all ones for PHASE_CYCLES+SYNC_STAGES cycles, so the synchronised result is settled.
- SAMPLE (1 cycle): each channel's synchronised bit is added to its ones-counter (width ceil(log2(VOTES+1))). Vote index increments. If index<VOTES, go to PRECHARGE with the same challenge; otherwise go to OUTPUT.
- OUTPUT: registers resp_data[i] = (ones[i] > VOTES/2) and resp_unstable[i] = (ones[i]!=0 && ones[i]!=VOTES); resp_challenge = current challenge; resp_valid=1.
- Outputs stay stable while resp_valid=1 and resp_ready=0 (backpressure is unbounded; puf_run stays 0 meanwhile).
- On handshake: counters clear, remaining count decrements, challenge increments modulo 2^CHALLENGE_WIDTH (wrap FF->00 for W=8). Next state is PRECHARGE, or DONE when remaining reaches 0.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency per challenge without backpressure: VOTES*(2*PHASE_CYCLES+SYNC_STAGES+1)+1 cycles to resp_valid.
- With VOTES=1, resp_unstable is always 0.
- Reset asserted mid-sweep aborts immediately. No response or done pulse is emitted after release; the next start begins a fresh sweep.

Test Plan:
- Stub cores result[i] = parity(challenge) XOR i. Defaults with NUM_CHANNELS=2, base=0x00, count=0: 256 responses in order 0x00..0xFF; resp_data matches stub; unstable all 0; single done pulse; busy low only afterwards.
- Wrap: base=0xFE, count=4 -> resp_challenge sequence FE, FF, 00, 01; then done.
- Voting: VOTES=3, stub returns 1,0,1 on successive evals for challenge 0x05 -> resp_data=1, resp_unstable=1. A 0,0,0 pattern -> resp_data=0, unstable=0.
- Backpressure: hold resp_ready=0 for 50 cycles on the 2nd response -> resp_valid, resp_data and resp_challenge stable and puf_run=0 throughout. No response is lost or duplicated; first-response latency equals 3*(2*10+2+1)+1 = 70 cycles.
- Mid-operation reset: assert reset during EVAL of the 3rd challenge -> all outputs zero asynchronously. After release, no resp_valid until a new start; a new start with base=0x10, count=1 gives one response for 0x10.
- Start while busy: pulse start with different base mid-sweep -> ignored; original sequence completes unchanged.

Source files
------------

// File: rtl/puf_sweep_engine.sv
// Sweeps a challenge range over NUM_CHANNELS delay-PUF cores, majority-votes VOTES evaluations per
// challenge and streams one voted response per challenge on a valid/ready interface.
module puf_sweep_engine #(
  parameter int CHALLENGE_WIDTH = 8,
  parameter int NUM_CHANNELS    = 1,
  parameter int PHASE_CYCLES    = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int VOTES           = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CHALLENGE_WIDTH-1:0] challenge_base,
  input  logic [CHALLENGE_WIDTH:0]   challenge_count,
  output logic                       busy,
  output logic                       done,
  output logic [CHALLENGE_WIDTH-1:0] puf_challenge,
  output logic [NUM_CHANNELS-1:0]    puf_run,
  input  logic [NUM_CHANNELS-1:0]    puf_result,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [CHALLENGE_WIDTH-1:0] resp_challenge,
  output logic [NUM_CHANNELS-1:0]    resp_data,
  output logic [NUM_CHANNELS-1:0]    resp_unstable
);

  localparam int OW = $clog2(VOTES + 1);
  localparam int CW = $clog2(PHASE_CYCLES + SYNC_STAGES + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(PHASE_CYCLES + SYNC_STAGES - 1);
  localparam logic [OW-1:0] VOTE_LAST = OW'(VOTES - 1);
  localparam logic [OW-1:0] VOTE_ALL  = OW'(VOTES);
  localparam logic [OW-1:0] HALF      = OW'(VOTES / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_EVAL, S_SAMPLE, S_OUT, S_DONE
  } state_t;

  state_t                                state_q, state_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [OW-1:0]                         vote_q, vote_d;
  logic [NUM_CHANNELS-1:0][OW-1:0]       ones_q, ones_d;
  logic [CHALLENGE_WIDTH-1:0]            chal_q, chal_d;
  logic [CHALLENGE_WIDTH:0]              rem_q, rem_d;
  logic                                  rv_q, rv_d;
  logic [CHALLENGE_WIDTH-1:0]            rc_q, rc_d;
  logic [NUM_CHANNELS-1:0]               rd_q, rd_d;
  logic [NUM_CHANNELS-1:0]               ru_q, ru_d;
  logic [SYNC_STAGES-1:0][NUM_CHANNELS-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], puf_result};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      chal_q  <= '0;
      rem_q   <= '0;
      rv_q    <= 1'b0;
      rc_q    <= '0;
      rd_q    <= '0;
      ru_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      chal_q  <= chal_d;
      rem_q   <= rem_d;
      rv_q    <= rv_d;
      rc_q    <= rc_d;
      rd_q    <= rd_d;
      ru_q    <= ru_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vote_d  = vote_q;
    ones_d  = ones_q;
    chal_d  = chal_q;
    rem_d   = rem_q;
    rv_d    = rv_q;
    rc_d    = rc_q;
    rd_d    = rd_q;
    ru_d    = ru_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d  = challenge_base;
          rem_d   = (challenge_count == '0) ? {1'b1, {CHALLENGE_WIDTH{1'b0}}} : challenge_count;
          cnt_d   = '0;
          vote_d  = '0;
          ones_d  = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // EVAL is stretched by SYNC_STAGES so the sampled bit has crossed the synchroniser.
      S_EVAL: begin
        if (cnt_q == EVAL_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          ones_d[i] = ones_q[i] + OW'(sync_q[SYNC_STAGES-1][i]);
        vote_d = vote_q + 1'b1;
        if (vote_q == VOTE_LAST) begin
          state_d = S_OUT;
          rv_d    = 1'b1;
          rc_d    = chal_q;
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            rd_d[i] = (ones_d[i] > HALF);
            ru_d[i] = (ones_d[i] != '0) && (ones_d[i] != VOTE_ALL);
          end
        end else begin
          state_d = S_PRE;
        end
      end
      S_OUT: begin
        if (rv_q && resp_ready) begin
          rv_d    = 1'b0;
          ones_d  = '0;
          vote_d  = '0;
          rem_d   = rem_q - 1'b1;
          chal_d  = chal_q + 1'b1;
          state_d = (rem_q == {{CHALLENGE_WIDTH{1'b0}}, 1'b1}) ? S_DONE : S_PRE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign puf_run        = {NUM_CHANNELS{state_q == S_EVAL}};
  assign puf_challenge  = chal_q;
  assign resp_valid     = rv_q;
  assign resp_challenge = rc_q;
  assign resp_data      = rd_q;
  assign resp_unstable  = ru_q;

endmodule

// File: tb/tb_puf_sweep_engine.sv
// Bench for puf_sweep_engine: stub PUF cores plus a vote-log reference model of the sweep.
module tb_puf_sweep_engine;
  localparam int W = 8, NC = 2, P = 10, S = 2, V = 3;
  localparam int LAT = V * (2 * P + S + 1) + 1;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, resp_ready = 1'b0;
  logic [W-1:0] challenge_base = '0;
  logic [W:0] challenge_count = '0;
  logic busy, done, resp_valid;
  logic [W-1:0] puf_challenge, resp_challenge;
  logic [NC-1:0] puf_run, puf_result, resp_data, resp_unstable;

  puf_sweep_engine #(.CHALLENGE_WIDTH(W), .NUM_CHANNELS(NC), .PHASE_CYCLES(P),
                     .SYNC_STAGES(S), .VOTES(V)) dut (
    .clk(clk), .reset(reset), .start(start), .challenge_base(challenge_base),
    .challenge_count(challenge_count), .busy(busy), .done(done),
    .puf_challenge(puf_challenge), .puf_run(puf_run), .puf_result(puf_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_challenge(resp_challenge),
    .resp_data(resp_data), .resp_unstable(resp_unstable));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // Stub cores: 0 = parity(challenge) ^ channel, 1 = random per evaluation, 2 = scripted.
  int mode = 0;
  logic [NC-1:0] eval_bits = '0;
  logic [NC-1:0] evlog[$];
  logic [NC-1:0] script[$];
  int evals = 0;
  bit run_seen = 0;

  assign puf_result = puf_run & eval_bits;

  always @(negedge clk) begin
    if (puf_run[0]) begin
      if (!run_seen) begin
        run_seen = 1;
        evlog.push_back(eval_bits);
        evals++;
      end
    end else begin
      run_seen = 0;
      case (mode)
        0:       eval_bits = {~(^puf_challenge), ^puf_challenge};
        1:       eval_bits = NC'($urandom);
        default: eval_bits = (evals < script.size()) ? script[evals] : '0;
      endcase
    end
  end

  logic [W-1:0] ob_chal[$], ex_chal[$];
  logic [NC-1:0] ob_data[$], ex_data[$], ob_unst[$], ex_unst[$];
  int first_lat, done_cnt, busy_viol, stable_viol, run_viol, extra_viol, timeout;

  // Drives one sweep and records what came out plus the model's expectation; no judging here.
  task automatic run_sweep(input logic [W-1:0] base, input logic [W:0] cnt, input int stall_pct,
                           input bit hold2nd, input bit poke);
    int cyc, nresp, hold, limit, done_cyc, ones;
    bit stalled, seen_done;
    logic [W-1:0] h_chal;
    logic [NC-1:0] h_data, h_unst, e_data, e_unst;
    ob_chal.delete(); ex_chal.delete(); ob_data.delete(); ex_data.delete();
    ob_unst.delete(); ex_unst.delete();
    first_lat = -1; done_cnt = 0; busy_viol = 0; stable_viol = 0; run_viol = 0;
    extra_viol = 0; timeout = 0; nresp = 0; hold = 0; stalled = 0; seen_done = 0; done_cyc = 0;
    limit = ((cnt == 0) ? 256 : int'(cnt)) * LAT * 4 + 500;
    @(negedge clk);
    evlog.delete(); evals = 0;
    start = 1; challenge_base = base; challenge_count = cnt; resp_ready = 0;
    @(negedge clk);
    cyc = 1;
    while (1) begin
      if (poke && cyc == 150) begin
        start = 1; challenge_base = base ^ 8'h55; challenge_count = 1;
      end else start = 0;
      if (done) done_cnt++;
      if (seen_done) begin
        if (busy || resp_valid) extra_viol++;
        if (cyc >= done_cyc + 5) break;
      end else if (done) begin
        seen_done = 1; done_cyc = cyc;
        if (busy) busy_viol++;
        if (resp_valid) extra_viol++;
      end else if (!busy) busy_viol++;
      if (resp_valid) begin
        if (first_lat < 0) first_lat = cyc;
        if (puf_run != '0) run_viol++;
        if (stalled && {resp_challenge, resp_data, resp_unstable} !== {h_chal, h_data, h_unst})
          stable_viol++;
        if (hold2nd && nresp == 1 && hold < 50) begin
          resp_ready = 0; hold++;
        end else resp_ready = ($urandom_range(99) >= stall_pct);
        if (resp_ready) begin
          ob_chal.push_back(resp_challenge); ob_data.push_back(resp_data);
          ob_unst.push_back(resp_unstable);
          ex_chal.push_back(base + W'(nresp));
          if (evlog.size() < V) begin
            ex_data.push_back('x); ex_unst.push_back('x);
          end else begin
            for (int ch = 0; ch < NC; ch++) begin
              ones = 0;
              for (int k = 0; k < V; k++) ones += int'(evlog[k][ch]);
              e_data[ch] = (2 * ones > V);
              e_unst[ch] = (ones != 0 && ones != V);
            end
            for (int k = 0; k < V; k++) void'(evlog.pop_front());
            ex_data.push_back(e_data); ex_unst.push_back(e_unst);
          end
          nresp++; stalled = 0;
        end else begin
          stalled = 1; h_chal = resp_challenge; h_data = resp_data; h_unst = resp_unstable;
        end
      end else begin
        resp_ready = 0; stalled = 0;
      end
      @(negedge clk);
      cyc++;
      if (cyc > limit) begin timeout = 1; break; end
    end
    start = 0; resp_ready = 0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, done, puf_run, puf_challenge, resp_valid, resp_challenge, resp_data, resp_unstable} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%0h want=0",
        {busy, done, puf_run, puf_challenge, resp_valid, resp_challenge, resp_data, resp_unstable});
    end
    @(negedge clk); reset = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, resp_valid, done} !== 3'b000) begin bad++; $display("FAIL idle_after_reset got=%b want=000", {busy, resp_valid, done}); end
  endtask

  task automatic test_full_sweep();
    logic [NC-1:0] par;
    mode = 0;
    run_sweep(8'h00, 9'd0, 20, 0, 0);
    total++; if (timeout != 0) begin bad++; $display("FAIL full_timeout got=%0d want=0", timeout); end
    total++; if (ob_chal.size() != 256) begin bad++; $display("FAIL full_count got=%0d want=256", ob_chal.size()); end
    total++; if (first_lat != LAT) begin bad++; $display("FAIL full_latency got=%0d want=%0d", first_lat, LAT); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done got=%0d want=1", done_cnt); end
    total++; if (busy_viol + extra_viol != 0) begin bad++; $display("FAIL full_busy got=%0d want=0", busy_viol + extra_viol); end
    for (int i = 0; i < ob_chal.size(); i++) begin
      par = {~(^ex_chal[i]), ^ex_chal[i]};
      total++; if (ob_chal[i] !== ex_chal[i]) begin bad++; $display("FAIL full_chal[%0d] got=%0h want=%0h", i, ob_chal[i], ex_chal[i]); end
      total++; if (ob_data[i] !== par) begin bad++; $display("FAIL full_data[%0d] got=%b want=%b", i, ob_data[i], par); end
      total++; if (ob_unst[i] !== 2'b00) begin bad++; $display("FAIL full_unstable[%0d] got=%b want=00", i, ob_unst[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] want[4];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    mode = 1;
    run_sweep(8'hFE, 9'd4, 30, 0, 0);
    total++; if (ob_chal.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", ob_chal.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done got=%0d want=1", done_cnt); end
    for (int i = 0; i < ob_chal.size() && i < 4; i++) begin
      total++; if (ob_chal[i] !== want[i]) begin bad++; $display("FAIL wrap_chal[%0d] got=%0h want=%0h", i, ob_chal[i], want[i]); end
      total++; if ({ob_data[i], ob_unst[i]} !== {ex_data[i], ex_unst[i]}) begin
        bad++; $display("FAIL wrap_vote[%0d] got=%b want=%b", i, {ob_data[i], ob_unst[i]}, {ex_data[i], ex_unst[i]}); end
    end
  endtask

  task automatic test_voting();
    // ch0 sees 1,0,1 and ch1 0,0,0 on 0x05; ch0 0,0,1 and ch1 1,1,1 on 0x06.
    mode = 2;
    script.delete();
    script.push_back(2'b01); script.push_back(2'b00); script.push_back(2'b01);
    script.push_back(2'b10); script.push_back(2'b10); script.push_back(2'b11);
    run_sweep(8'h05, 9'd2, 0, 0, 0);
    total++; if (ob_chal.size() != 2) begin bad++; $display("FAIL vote_count got=%0d want=2", ob_chal.size()); end
    total++; if (ob_chal[0] !== 8'h05) begin bad++; $display("FAIL vote_chal0 got=%0h want=05", ob_chal[0]); end
    total++; if (ob_data[0] !== 2'b01) begin bad++; $display("FAIL vote_data0 got=%b want=01", ob_data[0]); end
    total++; if (ob_unst[0] !== 2'b01) begin bad++; $display("FAIL vote_unstable0 got=%b want=01", ob_unst[0]); end
    total++; if (ob_data[1] !== 2'b10) begin bad++; $display("FAIL vote_data1 got=%b want=10", ob_data[1]); end
    total++; if (ob_unst[1] !== 2'b01) begin bad++; $display("FAIL vote_unstable1 got=%b want=01", ob_unst[1]); end
  endtask

  task automatic test_backpressure();
    mode = 1;
    run_sweep(W'($urandom), 9'd3, 0, 1, 0);
    total++; if (first_lat != LAT) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", first_lat, LAT); end
    total++; if (stable_viol != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stable_viol); end
    total++; if (run_viol != 0) begin bad++; $display("FAIL bp_run got=%0d want=0", run_viol); end
    total++; if (ob_chal.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", ob_chal.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    for (int i = 0; i < ob_chal.size(); i++) begin
      total++; if ({ob_chal[i], ob_data[i], ob_unst[i]} !== {ex_chal[i], ex_data[i], ex_unst[i]}) begin
        bad++; $display("FAIL bp_resp[%0d] got=%0h want=%0h", i, {ob_chal[i], ob_data[i], ob_unst[i]}, {ex_chal[i], ex_data[i], ex_unst[i]}); end
    end
  endtask

  task automatic test_start_while_busy();
    mode = 1;
    run_sweep(W'($urandom), 9'd6, 25, 0, 1);
    total++; if (ob_chal.size() != 6) begin bad++; $display("FAIL busy_start_count got=%0d want=6", ob_chal.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", done_cnt); end
    for (int i = 0; i < ob_chal.size(); i++) begin
      total++; if ({ob_chal[i], ob_data[i], ob_unst[i]} !== {ex_chal[i], ex_data[i], ex_unst[i]}) begin
        bad++; $display("FAIL busy_start_resp[%0d] got=%0h want=%0h", i, {ob_chal[i], ob_data[i], ob_unst[i]}, {ex_chal[i], ex_data[i], ex_unst[i]}); end
    end
  endtask

  task automatic test_mid_reset();
    int hs, n, viol;
    logic [W-1:0] b;
    mode = 0;
    @(negedge clk);
    start = 1; challenge_base = 8'h30; challenge_count = 9'd5; resp_ready = 1;
    @(negedge clk);
    start = 0; hs = 0; n = 0;
    while (n < 2000 && !(hs == 2 && puf_run != '0)) begin
      if (resp_valid) hs++;
      @(negedge clk); n++;
    end
    total++; if (n >= 2000) begin bad++; $display("FAIL midrst_reach_eval got=%0d want<2000", n); end
    #1 reset = 0;
    #1;
    total++;
    if ({busy, done, puf_run, puf_challenge, resp_valid, resp_challenge, resp_data, resp_unstable} !== '0) begin
      bad++; $display("FAIL midrst_outputs got=%0h want=0",
        {busy, done, puf_run, puf_challenge, resp_valid, resp_challenge, resp_data, resp_unstable});
    end
    repeat (2) @(negedge clk);
    reset = 1; resp_ready = 1; viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (resp_valid || busy || done) viol++;
    end
    resp_ready = 0;
    total++; if (viol != 0) begin bad++; $display("FAIL midrst_quiet got=%0d want=0", viol); end
    run_sweep(8'h10, 9'd1, 0, 0, 0);
    b = 8'h10;
    total++; if (ob_chal.size() != 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", ob_chal.size()); end
    total++; if (ob_chal[0] !== b) begin bad++; $display("FAIL midrst_chal got=%0h want=%0h", ob_chal[0], b); end
    total++; if (ob_data[0] !== {~(^b), ^b}) begin bad++; $display("FAIL midrst_data got=%b want=%b", ob_data[0], {~(^b), ^b}); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL midrst_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_random();
    logic [W:0] c;
    mode = 1;
    for (int r = 0; r < 3; r++) begin
      c = W'($urandom_range(6, 1));
      run_sweep(W'($urandom), c, $urandom_range(50), 0, 0);
      total++; if (ob_chal.size() != int'(c)) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", r, ob_chal.size(), c); end
      total++; if (done_cnt != 1 || busy_viol != 0 || extra_viol != 0) begin
        bad++; $display("FAIL rnd%0d_ctrl got=%0d/%0d/%0d want=1/0/0", r, done_cnt, busy_viol, extra_viol); end
      for (int i = 0; i < ob_chal.size(); i++) begin
        total++; if ({ob_chal[i], ob_data[i], ob_unst[i]} !== {ex_chal[i], ex_data[i], ex_unst[i]}) begin
          bad++; $display("FAIL rnd%0d_resp[%0d] got=%0h want=%0h", r, i, {ob_chal[i], ob_data[i], ob_unst[i]}, {ex_chal[i], ex_data[i], ex_unst[i]}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_wrap();
    test_voting();
    test_backpressure();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
